// File: rtl/ram_write_scheduler_pkg.sv
// rtl/ram_write_scheduler_pkg.sv - shared types and constants for the RAM write scheduler
package ram_sched_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } sched_state_t;

    localparam logic GNT_0 = 1'b0;
    localparam logic GNT_1 = 1'b1;

    function automatic logic [1:0] gnt_onehot(input logic idx);
        return (idx == GNT_1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_write_scheduler_if.sv
// rtl/ram_write_scheduler_if.sv - requester, sweep control, RAM write and hazard signals
interface ram_write_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  iInitStart;
    logic                  oInitBusy;
    logic                  iReqValid0;
    logic                  iReqValid1;
    logic [ADDR_WIDTH-1:0] iReqAddr0;
    logic [ADDR_WIDTH-1:0] iReqAddr1;
    logic [DATA_WIDTH-1:0] iReqData0;
    logic [DATA_WIDTH-1:0] iReqData1;
    logic                  oReqReady0;
    logic                  oReqReady1;
    logic [ADDR_WIDTH-1:0] iReadAddress0;
    logic [ADDR_WIDTH-1:0] iReadAddress1;
    logic                  oWriteEnable;
    logic [ADDR_WIDTH-1:0] oWriteAddress;
    logic [DATA_WIDTH-1:0] oDataIn;
    logic                  oHazard0;
    logic                  oHazard1;
    logic                  oAddrError;

    modport master (
        output iInitStart, iReqValid0, iReqValid1, iReqAddr0, iReqAddr1,
               iReqData0, iReqData1, iReadAddress0, iReadAddress1,
        input  oInitBusy, oReqReady0, oReqReady1, oWriteEnable, oWriteAddress,
               oDataIn, oHazard0, oHazard1, oAddrError
    );

    modport slave (
        input  iInitStart, iReqValid0, iReqValid1, iReqAddr0, iReqAddr1,
               iReqData0, iReqData1, iReadAddress0, iReadAddress1,
        output oInitBusy, oReqReady0, oReqReady1, oWriteEnable, oWriteAddress,
               oDataIn, oHazard0, oHazard1, oAddrError
    );

endinterface

// File: rtl/ram_write_scheduler_rr_arbiter2.sv
// rtl/ram_write_scheduler_rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter2
    import ram_sched_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic r_last;
    logic w_idx;
    logic w_any;

    // Every grant is an accept (grant implies valid), so the pointer follows any grant.
    always_comb begin
        w_any = i_en && (|i_req);
        if (i_req[0] && i_req[1]) begin
            w_idx = (r_last == GNT_0) ? GNT_1 : GNT_0;
        end else if (i_req[1]) begin
            w_idx = GNT_1;
        end else begin
            w_idx = GNT_0;
        end
        o_gnt     = w_any ? gnt_onehot(w_idx) : 2'b00;
        o_gnt_idx = w_idx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= GNT_1;
        end else if (w_any) begin
            r_last <= w_idx;
        end
    end

endmodule

// File: rtl/ram_write_scheduler.sv
// rtl/ram_write_scheduler.sv - shares the RAM write port between two requesters and runs the clear sweep
module ram_write_scheduler
    import ram_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_SIZE   = 31
) (
    input  logic                 Clock,
    input  logic                 Reset,
    ram_write_scheduler_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_addr_err;

    logic                  w_sweep_load;
    logic                  w_sweep_inc;
    logic                  w_arb_en;
    logic [1:0]            w_gnt;
    logic                  w_gnt_idx;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_acc_oob;
    logic                  w_in_init;

    always_comb begin
        w_state_next = r_state;
        w_sweep_load = 1'b0;
        w_sweep_inc  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.iInitStart) begin
                    w_state_next = ST_INIT;
                    w_sweep_load = 1'b1;
                end
            end
            ST_INIT: begin
                w_sweep_inc = 1'b1;
                if (r_count == LP_LAST_ADDR) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Readies are withheld on the start-request cycle so no write races the sweep.
    assign w_arb_en = (r_state == ST_RUN) && !bus.iInitStart && !Reset;

    rr_arbiter2 u_arb (
        .i_clk     (Clock),
        .i_rst     (Reset),
        .i_en      (w_arb_en),
        .i_req     ({bus.iReqValid1, bus.iReqValid0}),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_accept   = |w_gnt;
    assign w_acc_addr = (w_gnt_idx == GNT_1) ? bus.iReqAddr1 : bus.iReqAddr0;
    assign w_acc_data = (w_gnt_idx == GNT_1) ? bus.iReqData1 : bus.iReqData0;
    assign w_acc_oob  = (w_acc_addr > LP_LAST_ADDR);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_RUN;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_sweep_load) begin
                r_count <= '0;
            end else if (w_sweep_inc) begin
                r_count <= r_count + 1'b1;
            end
            r_we       <= w_accept && !w_acc_oob;
            r_addr_err <= w_accept && w_acc_oob;
            if (w_accept) begin
                r_waddr <= w_acc_addr;
                r_wdata <= w_acc_data;
            end
        end
    end

    // Sweep drives the write port directly from the counter so busy and the sweep writes line up.
    assign w_in_init = (r_state == ST_INIT);

    assign bus.oInitBusy     = w_in_init;
    assign bus.oWriteEnable  = w_in_init || r_we;
    assign bus.oWriteAddress = w_in_init ? r_count : r_waddr;
    assign bus.oDataIn       = w_in_init ? '0 : r_wdata;
    assign bus.oAddrError    = r_addr_err;
    assign bus.oReqReady0    = w_gnt[0];
    assign bus.oReqReady1    = w_gnt[1];
    assign bus.oHazard0      = bus.oWriteEnable && (bus.iReadAddress0 == bus.oWriteAddress);
    assign bus.oHazard1      = bus.oWriteEnable && (bus.iReadAddress1 == bus.oWriteAddress);

endmodule

// File: tb/tb_ram_write_scheduler.sv
// tb/tb_ram_write_scheduler.sv - scoreboard bench for ram_write_scheduler
module tb_ram_write_scheduler;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MS = 31;

    typedef struct {
        int          cyc;
        logic        we;
        logic        err;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    ram_write_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram    [0:255];
    logic [DW-1:0] shadow [0:255];
    always @(posedge Clock) if (bus.oWriteEnable) ram[bus.oWriteAddress] <= bus.oDataIn;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    int   last_gnt = 1;
    exp_t q[$];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    exp_t me;
    always @(negedge Clock) begin
        if (mon_en && !Reset) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                me = q.pop_front();
                check("write_enable", bus.oWriteEnable, me.we);
                check("addr_error", bus.oAddrError, me.err);
                if (me.we) begin
                    check("write_address", bus.oWriteAddress, me.addr);
                    check("write_data", bus.oDataIn, me.data);
                end
                check("hazard0", bus.oHazard0, me.we && (bus.iReadAddress0 == me.addr));
                check("hazard1", bus.oHazard1, me.we && (bus.iReadAddress1 == me.addr));
            end else begin
                check("idle_write_enable", bus.oWriteEnable, 0);
                check("idle_addr_error", bus.oAddrError, 0);
                check("idle_hazards", {bus.oHazard1, bus.oHazard0}, 0);
            end
        end
    end

    task automatic drive_idle_inputs();
        bus.iInitStart = 1'b0;
        bus.iReqValid0 = 1'b0;
        bus.iReqValid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle_inputs();
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
        end
    endtask

    task automatic cycle_req(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        int   g;
        exp_t e;
        bus.iInitStart    = 1'b0;
        bus.iReqValid0    = v0; bus.iReqAddr0 = a0; bus.iReqData0 = d0;
        bus.iReqValid1    = v1; bus.iReqAddr1 = a1; bus.iReqData1 = d1;
        bus.iReadAddress0 = r0;
        bus.iReadAddress1 = r1;
        g = -1;
        if (v0 && v1)  g = (last_gnt == 0) ? 1 : 0;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        @(negedge Clock);
        check("ready0", bus.oReqReady0, g == 0);
        check("ready1", bus.oReqReady1, g == 1);
        @(posedge Clock); #1;
        if (g >= 0) begin
            last_gnt = g;
            e.cyc  = cyc;
            e.addr = (g == 1) ? a1 : a0;
            e.data = (g == 1) ? d1 : d0;
            e.we   = (int'(e.addr) <= MS);
            e.err  = !e.we;
            q.push_back(e);
            if (e.we) shadow[e.addr] = e.data;
        end
        drive_idle_inputs();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.iReqValid0 = 1'b1;
        bus.iReqValid1 = 1'b1;
        bus.iReadAddress0 = '0;
        bus.iReadAddress1 = '0;
        #1;
        check("rst_ready", {bus.oReqReady1, bus.oReqReady0}, 0);
        check("rst_write_enable", bus.oWriteEnable, 0);
        check("rst_write_address", bus.oWriteAddress, 0);
        check("rst_data_in", bus.oDataIn, 0);
        check("rst_busy", bus.oInitBusy, 0);
        check("rst_addr_error", bus.oAddrError, 0);
        check("rst_hazards", {bus.oHazard1, bus.oHazard0}, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        drive_idle_inputs();
        last_gnt = 1;
        q.delete();
    endtask

    task automatic sweep(input int abort_at);
        bus.iInitStart = 1'b1;
        bus.iReqValid0 = 1'b1;
        bus.iReqValid1 = 1'b1;
        @(negedge Clock);
        check("start_ready", {bus.oReqReady1, bus.oReqReady0}, 0);
        check("start_busy", bus.oInitBusy, 0);
        @(posedge Clock); #1;
        mon_en = 1'b0;
        for (int k = 0; k <= MS; k++) begin
            bus.iInitStart    = 1'($urandom_range(0, 1));
            bus.iReadAddress0 = AW'(k);
            bus.iReadAddress1 = AW'(k + 1);
            @(negedge Clock);
            check("sweep_busy", bus.oInitBusy, 1);
            check("sweep_write_enable", bus.oWriteEnable, 1);
            check("sweep_address", bus.oWriteAddress, k);
            check("sweep_data", bus.oDataIn, 0);
            check("sweep_ready", {bus.oReqReady1, bus.oReqReady0}, 0);
            check("sweep_hazards", {bus.oHazard1, bus.oHazard0}, 1);
            shadow[k] = '0;
            @(posedge Clock); #1;
            if (k == abort_at) begin
                Reset = 1'b1;
                #1;
                check("abort_busy", bus.oInitBusy, 0);
                check("abort_write_enable", bus.oWriteEnable, 0);
                check("abort_ready", {bus.oReqReady1, bus.oReqReady0}, 0);
                @(posedge Clock); #1;
                Reset = 1'b0;
                drive_idle_inputs();
                last_gnt = 1;
                q.delete();
                mon_en = 1'b1;
                return;
            end
        end
        drive_idle_inputs();
        @(negedge Clock);
        check("sweep_done_busy", bus.oInitBusy, 0);
        check("sweep_done_write_enable", bus.oWriteEnable, 0);
        @(posedge Clock); #1;
        mon_en = 1'b1;
    endtask

    task automatic readback();
        for (int i = 0; i <= MS; i++) begin
            check($sformatf("ram_word_%0d", i), ram[i], shadow[i]);
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive_idle_inputs();
        bus.iReqAddr0 = '0; bus.iReqAddr1 = '0;
        bus.iReqData0 = '0; bus.iReqData1 = '0;
        bus.iReadAddress0 = '0; bus.iReadAddress1 = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        @(posedge Clock); #1;
        do_reset();
        mon_en = 1'b1;

        sweep(-1);
        idle(2);
        readback();

        do_reset();
        for (int i = 0; i < 4; i++)
            cycle_req(1'b1, 8'd1, DW'($urandom), 1'b1, 8'd2, DW'($urandom), 8'd0, 8'd0);

        cycle_req(1'b1, 8'd5, 16'hABCD, 1'b0, 8'd0, 16'h0, 8'd0, 8'd0);
        idle(3);
        check("word5", ram[5], 16'hABCD);

        cycle_req(1'b1, 8'd7, 16'h1234, 1'b0, 8'd0, 16'h0, 8'd0, 8'd0);
        cycle_req(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 8'd3, 8'd7);

        cycle_req(1'b0, 8'd0, 16'h0, 1'b1, 8'd40, 16'hDEAD, 8'd40, 8'd0);
        idle(2);

        cycle_req(1'b1, 8'd9, 16'h5555, 1'b0, 8'd0, 16'h0, 8'd9, 8'd9);
        sweep(-1);
        idle(2);
        readback();

        for (int i = 0; i < 400; i++) begin
            cycle_req(1'($urandom_range(0, 9) < 7), AW'($urandom_range(0, 40)), DW'($urandom),
                      1'($urandom_range(0, 9) < 7), AW'($urandom_range(0, 40)), DW'($urandom),
                      AW'($urandom_range(0, 35)), AW'($urandom_range(0, 35)));
        end
        idle(3);
        readback();

        sweep(10);
        cycle_req(1'b1, 8'd20, 16'hBEEF, 1'b1, 8'd21, 16'hCAFE, 8'd0, 8'd0);
        idle(3);
        readback();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

endmodule
